// File: rtl/i2s_slave_rx_if.sv
// i2s_slave_rx_if: I2S pins plus the frame handshake between receiver and consumer
interface i2s_slave_rx_if #(
  parameter int WIDTH = 16
);
  logic bclk_in;
  logic lrclk_in;
  logic sdata_in;
  logic ready_in;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic valid_out;
  logic overrun_out;
  logic locked_out;
  modport master (
    output bclk_in, lrclk_in, sdata_in, ready_in,
    input left_out, right_out, valid_out, overrun_out, locked_out
  );
  modport slave (
    input bclk_in, lrclk_in, sdata_in, ready_in,
    output left_out, right_out, valid_out, overrun_out, locked_out
  );
endinterface

// File: rtl/i2s_slave_rx.sv
// i2s_slave_rx: oversampling I2S slave receiver delivering stereo frames with valid/ready
module i2s_slave_rx #(
  parameter int WIDTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 64
) (
  input logic clk_in,
  input logic ar,
  i2s_slave_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT);
  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] bclk_s, lr_s, dat_s;
  logic bclk_prev, rise, stb, lr_smp, dat_smp, lr_last, have_lr;
  logic boundary, tout, frame_done, latch_left;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [WIDTH-1:0] word, aligned, hold;
  assign rise = bclk_s[SYNC_STAGES-1] & ~bclk_prev;
  assign boundary = stb & have_lr & (lr_smp != lr_last);
  assign tout = ~rise & (tcnt == T_LAST);
  assign aligned = word << (W_C - cnt);
  // input synchronizers; bit 0 of each chain faces the asynchronous pin
  always_ff @(posedge clk_in)
    if (ar) begin
      bclk_s <= '0;
      lr_s <= '0;
      dat_s <= '0;
    end else begin
      bclk_s <= {bclk_s[SYNC_STAGES-2:0], bus.bclk_in};
      lr_s <= {lr_s[SYNC_STAGES-2:0], bus.lrclk_in};
      dat_s <= {dat_s[SYNC_STAGES-2:0], bus.sdata_in};
    end
  // sample lr/data on each bclk rise; they are evaluated one cycle later via stb
  always_ff @(posedge clk_in)
    if (ar) begin
      bclk_prev <= 1'b0;
      stb <= 1'b0;
      lr_smp <= 1'b0;
      dat_smp <= 1'b0;
    end else begin
      bclk_prev <= bclk_s[SYNC_STAGES-1];
      stb <= rise;
      lr_smp <= rise ? lr_s[SYNC_STAGES-1] : lr_smp;
      dat_smp <= rise ? dat_s[SYNC_STAGES-1] : dat_smp;
    end
  // remember the lr of the previous strobe; the first strobe only seeds it
  always_ff @(posedge clk_in)
    if (ar) begin
      lr_last <= 1'b0;
      have_lr <= 1'b0;
    end else if (stb) begin
      lr_last <= lr_smp;
      have_lr <= 1'b1;
    end
  // cycles since last bclk rise, saturating once the lock is dropped
  always_ff @(posedge clk_in)
    if (ar) tcnt <= T_END;
    else tcnt <= rise ? '0 : (tcnt == T_END) ? tcnt : tcnt + 1'b1;
  // deserializer: restart per channel, the boundary bit is the I2S delay slot
  always_ff @(posedge clk_in)
    if (ar || tout || boundary) begin
      cnt <= '0;
      word <= '0;
    end else if (stb && cnt < W_C) begin
      word <= {word[WIDTH-2:0], dat_smp};
      cnt <= cnt + 1'b1;
    end
  // left word waits here until its right partner completes the frame
  always_ff @(posedge clk_in)
    if (ar || tout) hold <= '0;
    else if (latch_left) hold <= aligned;
  // frame alignment state register
  always_ff @(posedge clk_in)
    state_q <= ar ? UNLOCKED : state_d;
  // next state: only a boundary into left can lock; right boundary closes a frame
  always_comb begin
    latch_left = boundary & ~tout & (state_q == LEFT);
    frame_done = boundary & ~tout & (state_q == RIGHT);
    state_d = tout ? UNLOCKED :
              ~boundary ? state_q :
              (state_q == LEFT) ? RIGHT :
              (state_q == RIGHT || !lr_smp) ? LEFT : UNLOCKED;
  end
  // output frame register with handshake; a new frame beats a same-cycle accept
  always_ff @(posedge clk_in)
    if (ar) begin
      bus.left_out <= '0;
      bus.right_out <= '0;
      bus.valid_out <= 1'b0;
      bus.overrun_out <= 1'b0;
      bus.locked_out <= 1'b0;
    end else begin
      bus.overrun_out <= frame_done & bus.valid_out & ~bus.ready_in;
      if (frame_done) begin
        bus.left_out <= hold;
        bus.right_out <= aligned;
        bus.valid_out <= 1'b1;
      end else if (bus.ready_in) bus.valid_out <= 1'b0;
      bus.locked_out <= frame_done ? 1'b1 : tout ? 1'b0 : bus.locked_out;
    end
endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb_i2s_slave_rx: scoreboard bench bit-banging I2S frames into i2s_slave_rx
module tb_i2s_slave_rx;
  localparam int W = 16;
  localparam int SYNC = 2;
  localparam int TMO = 64;
  logic clk_in = 1'b0;
  logic ar = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n_ovr = 0;
  logic [2*W-1:0] q[$];
  i2s_slave_rx_if #(.WIDTH(W)) bus();
  i2s_slave_rx #(.WIDTH(W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in),
    .ar(ar),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1, "watchdog");
  end
  // acceptance monitor: overrun drops the oldest expectation, accepts pop and compare
  initial forever begin
    logic [2*W-1:0] exp;
    @(negedge clk_in);
    #1;
    if (bus.overrun_out) begin
      n_ovr++;
      if (q.size() > 0) exp = q.pop_front();
    end
    if (bus.valid_out && bus.ready_in) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL frame: got %h/%h, required no frame", bus.left_out, bus.right_out);
      end else begin
        exp = q.pop_front();
        if ({bus.left_out, bus.right_out} !== exp) begin
          n_err++;
          $display("FAIL frame: got %h/%h, required %h/%h", bus.left_out, bus.right_out,
                   exp[2*W-1:W], exp[W-1:0]);
        end
      end
    end
  end
  task automatic rise_edge(input logic lr, input logic d);
    @(negedge clk_in);
    bus.bclk_in = 1'b0;
    bus.lrclk_in = lr;
    bus.sdata_in = d;
    @(negedge clk_in);
    @(negedge clk_in);
    bus.bclk_in = 1'b1;
  endtask
  task automatic bit_clk(input logic lr, input logic d);
    rise_edge(lr, d);
    @(negedge clk_in);
  endtask
  task automatic send_word(input logic lr, input logic [31:0] val, input int nbits);
    bit_clk(lr, 1'b0);
    for (int i = nbits - 1; i >= 0; i--) bit_clk(lr, val[i]);
  endtask
  task automatic preamble();
    repeat (TMO + 8) @(negedge clk_in);
    bit_clk(1'b1, 1'b0);
    bit_clk(1'b1, 1'b1);
  endtask
  task automatic check_latency(input string name);
    repeat (SYNC + 1) @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early: valid_out=%b, required 0", name, bus.valid_out);
    end
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: valid_out=%b, required 1", name, bus.valid_out);
    end
  endtask
  task automatic test_reset();
    bus.bclk_in = 1'b0;
    bus.lrclk_in = 1'b1;
    bus.sdata_in = 1'b0;
    bus.ready_in = 1'b1;
    ar = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    n_cmp++;
    if ({bus.left_out, bus.right_out, bus.valid_out, bus.overrun_out, bus.locked_out} !== '0) begin
      n_err++;
      $display("FAIL reset: got %h/%h v%b o%b l%b, required all 0", bus.left_out, bus.right_out,
               bus.valid_out, bus.overrun_out, bus.locked_out);
    end
    @(negedge clk_in);
    ar = 1'b0;
  endtask
  task automatic test_basic();
    bus.ready_in = 1'b1;
    preamble();
    send_word(1'b0, 32'hA5C3, 16);
    send_word(1'b1, 32'h1234, 16);
    q.push_back({16'hA5C3, 16'h1234});
    rise_edge(1'b0, 1'b0);
    check_latency("basic");
    n_cmp++;
    if (bus.locked_out !== 1'b1) begin
      n_err++;
      $display("FAIL basic_lock: locked_out=%b, required 1", bus.locked_out);
    end
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse: valid_out=%b, required 0", bus.valid_out);
    end
  endtask
  task automatic test_overrun();
    bus.ready_in = 1'b0;
    n_ovr = 0;
    preamble();
    send_word(1'b0, 32'h1111, 16);
    send_word(1'b1, 32'h2222, 16);
    q.push_back({16'h1111, 16'h2222});
    send_word(1'b0, 32'h3333, 16);
    send_word(1'b1, 32'h4444, 16);
    q.push_back({16'h3333, 16'h4444});
    bit_clk(1'b0, 1'b0);
    repeat (10) @(negedge clk_in);
    n_cmp++;
    if (n_ovr !== 1 || bus.valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL overrun: pulses=%0d valid=%b, required 1 pulse valid 1", n_ovr, bus.valid_out);
    end
    bus.ready_in = 1'b1;
    @(negedge clk_in);
    bus.ready_in = 1'b0;
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: valid_out=%b, required 0", bus.valid_out);
    end
  endtask
  task automatic test_width(input logic [31:0] l, input logic [31:0] r, input int nbits,
                            input logic [W-1:0] el, input logic [W-1:0] er);
    bus.ready_in = 1'b1;
    preamble();
    send_word(1'b0, l, nbits);
    send_word(1'b1, r, nbits);
    q.push_back({el, er});
    bit_clk(1'b0, 1'b0);
    repeat (10) @(negedge clk_in);
  endtask
  task automatic test_mid_right();
    ar = 1'b1;
    @(negedge clk_in);
    ar = 1'b0;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 10; i++) bit_clk(1'b1, 1'b1);
    send_word(1'b0, 32'hBEEF, 16);
    send_word(1'b1, 32'h0F0F, 16);
    n_cmp++;
    if (bus.valid_out !== 1'b0 || bus.locked_out !== 1'b0) begin
      n_err++;
      $display("FAIL midright_partial: valid=%b locked=%b, required 0 0", bus.valid_out, bus.locked_out);
    end
    q.push_back({16'hBEEF, 16'h0F0F});
    rise_edge(1'b0, 1'b0);
    check_latency("midright");
    n_cmp++;
    if (bus.locked_out !== 1'b1) begin
      n_err++;
      $display("FAIL midright_lock: locked_out=%b, required 1", bus.locked_out);
    end
  endtask
  task automatic test_timeout();
    bus.ready_in = 1'b0;
    preamble();
    send_word(1'b0, 32'h5555, 16);
    send_word(1'b1, 32'hAAAA, 16);
    q.push_back({16'h5555, 16'hAAAA});
    rise_edge(1'b0, 1'b0);
    repeat (SYNC + TMO) @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.locked_out !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_early: locked_out=%b, required 1", bus.locked_out);
    end
    @(posedge clk_in);
    #1;
    n_cmp++;
    if (bus.locked_out !== 1'b0 || bus.valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_drop: locked=%b valid=%b, required 0 1", bus.locked_out, bus.valid_out);
    end
    @(negedge clk_in);
    bus.ready_in = 1'b1;
    @(negedge clk_in);
    bus.ready_in = 1'b0;
    preamble();
    send_word(1'b0, 32'h0102, 16);
    send_word(1'b1, 32'h0304, 16);
    q.push_back({16'h0102, 16'h0304});
    rise_edge(1'b0, 1'b0);
    check_latency("relock");
    n_cmp++;
    if (bus.locked_out !== 1'b1) begin
      n_err++;
      $display("FAIL relock: locked_out=%b, required 1", bus.locked_out);
    end
    for (int i = 0; i < 5; i++) bit_clk(1'b0, 1'b1);
    ar = 1'b1;
    @(posedge clk_in);
    #1;
    n_cmp++;
    if ({bus.left_out, bus.right_out, bus.valid_out, bus.overrun_out, bus.locked_out} !== '0) begin
      n_err++;
      $display("FAIL midreset: got %h/%h v%b l%b, required all 0", bus.left_out, bus.right_out,
               bus.valid_out, bus.locked_out);
    end
    q.delete();
    @(negedge clk_in);
    ar = 1'b0;
  endtask
  task automatic test_back_to_back();
    logic [15:0] l, r;
    bus.ready_in = 1'b1;
    preamble();
    for (int f = 0; f < 4; f++) begin
      l = 16'($urandom);
      r = 16'($urandom);
      send_word(1'b0, {16'h0, l}, 16);
      send_word(1'b1, {16'h0, r}, 16);
      q.push_back({l, r});
    end
    bit_clk(1'b0, 1'b0);
    repeat (10) @(negedge clk_in);
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_width(32'hABCDEF, 32'h123456, 24, 16'hABCD, 16'h1234);
    test_width(32'hC5, 32'h7E, 8, 16'hC500, 16'h7E00);
    test_mid_right();
    test_timeout();
    test_back_to_back();
    repeat (5) @(negedge clk_in);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d frames never delivered, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- I2S slave-side receiver: accepts external BCLK, LRCLK and SDATA from a codec or master and deserializes stereo samples into the clk_in domain.
- Counterpart to our bit-clock master. Used when an external device owns the I2S clocks.
- Oversamples all three inputs with clk_in. Presents left/right words with a valid/ready handshake.

Parameters:
WIDTH, 16, captured sample width per channel (bits)
SYNC_STAGES, 2, flop stages in each input synchronizer (min 2)
TIMEOUT, 64, clk_in cycles without a BCLK rising edge before lock is dropped

Ports:
clk_in  input  1  system clock; all logic on rising edge; must be >= 4x bclk_in frequency
ar  input  1  reset, synchronous, active-high
bclk_in  input  1  external I2S bit clock (asynchronous)
lrclk_in  input  1  external word select, 0 = left, 1 = right (asynchronous)
sdata_in  input  1  external serial data, MSB first (asynchronous)
ready_in  input  1  consumer accepts frame when high with valid_out
left_out  output  WIDTH  last complete left sample
right_out  output  WIDTH  last complete right sample
valid_out  output  1  frame available; held until accepted
overrun_out  output  1  one-cycle pulse: new frame replaced an unaccepted one
locked_out  output  1  receiver aligned to frame boundaries

Behaviour:
- Reset: ar high on a clk_in edge clears all outputs to 0, clears the synchronizers, bit counter and shift registers, and forces state UNLOCKED. Reset wins over every simultaneous event.
- Synchronizers: each input passes through SYNC_STAGES flops. A prev-bclk flop gives a one-cycle rise strobe when sync=1 and prev=0. lrclk and sdata are sampled from their synchronized values on the rise strobe only.
- Channel boundary: a rise strobe at which sampled lr differs from the lr sampled at the previous strobe.
  - The data bit at the boundary strobe is ignored (I2S one-bit delay).
  - The bit counter resets to 0.
- Shifting: at each following strobe, if counter < WIDTH, shift the bit in MSB-first and increment; bits beyond WIDTH are discarded (truncation).
- Short words: at a boundary with counter < WIDTH, the word is left-justified and remaining LSBs are zero-filled.
- States:
  - UNLOCKED: wait for a boundary with new lr=0 -> LEFT.
  - LEFT: boundary (lr 0->1) latches left word into holding reg -> RIGHT.
  - RIGHT: boundary (lr 1->0) completes a frame -> LEFT.
- Frame completion, registered on the same clk_in edge as the state transition:
  - left_out <= holding, right_out <= right word, valid_out <= 1, locked_out <= 1.
  - If valid_out was already 1 and ready_in was 0 on that cycle: data is overwritten, valid_out stays 1, overrun_out pulses one cycle.
- Latency: valid_out rises exactly SYNC_STAGES+2 clk_in cycles after the bclk_in rising edge on which lrclk_in is first sampled low after high.
- Handshake: valid_out && ready_in on a clk_in edge clears valid_out next cycle. A frame completing on that same edge wins: valid_out stays 1, new data is loaded, no overrun.
- The first frame after reset or after unlock is emitted only if both its left and right halves were captured from a left boundary. A partial right half seen in UNLOCKED is discarded.
- Timeout: a counter counts clk_in cycles since the last rise strobe. On reaching TIMEOUT:
  - locked_out <= 0, state -> UNLOCKED, partial words and holding reg are discarded.
  - A pending valid_out frame is kept until accepted.
- Mid-frame reset: all partial data is lost; relock requires a new left boundary.

Test Plan:
- WIDTH=16, 16 bclk per channel, left 0xA5C3, right 0x1234, ready_in=1 -> one valid_out pulse, left_out=0xA5C3, right_out=0x1234, locked_out=1, valid_out edge exactly SYNC_STAGES+2 clk_in after frame-ending bclk rise.
- ready_in=0 across frames (0x1111,0x2222) then (0x3333,0x4444) -> second completion pulses overrun_out once; outputs 0x3333/0x4444; valid_out stays 1 until ready_in=1 for one cycle, then 0.
- 24 bits per channel, left 0xABCDEF, right 0x123456 -> left_out=0xABCD, right_out=0x1234.
- 8 bits per channel, left 0xC5, right 0x7E -> left_out=0xC500, right_out=0x7E00.
- Stream starts mid-right word after reset -> no valid_out for that partial frame; first valid_out carries the first full left+right pair; locked_out rises with it.
- bclk_in held static -> locked_out falls exactly TIMEOUT cycles after last rise strobe; pending valid_out retained. Clock restart -> relock on next full frame. Assert ar mid-word -> all outputs 0 next cycle.
